ram_even_bank: RTL and testbench
================================

Name: ram_even_bank

Overview:
- Dual-channel pixel store for the JPEG-2000 5/3 lifting datapath.
- Each channel (0 and 1) holds one even-sample RAM and one odd-sample RAM, each 128 x 20 bit, with independent address, write enable and registered read port.
- Writes store either raw pixel data or a lifting-step result (predict or update, forward or inverse) computed from the incoming sample and its left/right neighbours.
- The wavelet sequencer feeds this block and reads the results back.

Parameters:
- DW, 20, sample width (two's complement)
- AW, 7, address width; depth = 2**AW = 128 words per RAM

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pix_addr_even  in  7  channel-0 even RAM address
- pix_addr_odd  in  7  channel-0 odd RAM address
- pix_we_even  in  1  channel-0 even RAM write enable
- pix_we_odd  in  1  channel-0 odd RAM write enable
- pix_din_even  in  20  channel-0 even write sample
- pix_din_odd  in  20  channel-0 odd write sample
- pix_left  in  20  channel-0 left neighbour
- pix_right  in  20  channel-0 right neighbour
- pix_dout_even  out  20  channel-0 even read data (registered)
- pix_dout_odd  out  20  channel-0 odd read data (registered)
- pix_addr_even1, pix_addr_odd1, pix_we_even1, pix_we_odd1, pix_din_even1, pix_din_odd1, pix_left1, pix_right1  in  as above  channel-1 equivalents
- pix_dout_even1, pix_dout_odd1  out  20  channel-1 read data
- pix_even_odd  in  1  lift step select: 0 = predict, 1 = update (shared by both channels)
- pix_fwd_inv  in  1  1 = forward transform, 0 = inverse (shared)
- pix_p  in  1  1 = write lifting result, 0 = write raw din (shared)

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a clk edge with rst=1, all four dout registers go to 0 and no writes occur.
- RAM contents are not cleared by reset.
- Write value per RAM: wv = pix_p ? lift(din, left, right) : din, using that channel's left/right.
- Let s = sign-extended left + right, 21 bits.
- Predict (pix_even_odd=0): d = s >>> 1, arithmetic shift. Forward: din - d. Inverse: din + d.
- Update (pix_even_odd=1): d = (s + 2) >>> 2. Forward: din + d. Inverse: din - d.
- All results are truncated to 20 bits (wrap modulo 2^20). No saturation.
- Write: on a clk edge with we=1 and rst=0, mem[addr] <= wv.
- Read: every clk edge with rst=0, dout <= mem[addr]. Read latency is 1 cycle.
- Same-cycle read and write to the same address returns the old contents (read-before-write).
- All four RAMs operate fully independently and simultaneously. Different channels and different banks never interact.
- Addresses 0..127 are all valid. No out-of-range condition exists.
- Neighbour and control inputs are used only in the cycle the write occurs. No pipeline state is kept beyond the memories and dout registers.

Optional Feature:
- Macro RD_BYPASS_EN.
- When defined: each RAM is write-first. With we=1 and the same address, dout loads wv in the same edge.
- When undefined: read-before-write as described above.

Test Plan:
- Reset and raw write: rst=1 for 2 cycles gives all dout=0. With pix_p=0, write 0x12345 to even addr 5 (ch0). Read addr 5; dout_even=0x12345 one cycle later, other douts unaffected.
- Forward predict, ch0 odd: pix_p=1, pix_even_odd=0, pix_fwd_inv=1, din=100, left=40, right=61. Stored 50. Inverse with din=50 and same neighbours stores 100.
- Forward update, ch1 even: pix_even_odd=1, pix_fwd_inv=1, din=10, left1=5, right1=6. Stored 13. Inverse with din=13 stores 10.
- Negative/wrap: forward predict, din=0, left=0xFFFFD (-3), right=0. Stored 2. Raw din=0x7FFFF then forward update with left=right=0x7FFFF wraps to 0x7FFFF + 0x40000 mod 2^20 = 0xBFFFF.
- Concurrency: all four we=1 at distinct data and addrs in one cycle. All four read back correctly. Same-address read/write returns the old value, or the new value under RD_BYPASS_EN.
- Reset mid-operation: assert rst with we=1. No write occurs, douts go to 0, and earlier contents are still readable after rst deasserts.

Source files
------------

// File: rtl/ram_even_bank.sv
// Dual-channel even/odd sample store for the 5/3 lifting datapath: four independent 128x20 RAMs
// with an inline lifting-step write path. Define RD_BYPASS_EN to make each RAM write-first.

module ram_even_bank_ram #(
  parameter int DW = 20,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [DW-1:0] wv,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_r [2**AW];
  logic [DW-1:0] dout_r;

  // Storage write; reset only blocks the write, contents survive it.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem_r[addr] <= wv;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= {DW{1'b0}};
    end else begin
`ifdef RD_BYPASS_EN
      dout_r <= we ? wv : mem_r[addr];
`else
      dout_r <= mem_r[addr];
`endif
    end
  end

  assign dout = dout_r;

endmodule

module ram_even_bank #(
  parameter int DW = 20,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pix_addr_even,
  input  logic [AW-1:0] pix_addr_odd,
  input  logic          pix_we_even,
  input  logic          pix_we_odd,
  input  logic [DW-1:0] pix_din_even,
  input  logic [DW-1:0] pix_din_odd,
  input  logic [DW-1:0] pix_left,
  input  logic [DW-1:0] pix_right,
  output logic [DW-1:0] pix_dout_even,
  output logic [DW-1:0] pix_dout_odd,
  input  logic [AW-1:0] pix_addr_even1,
  input  logic [AW-1:0] pix_addr_odd1,
  input  logic          pix_we_even1,
  input  logic          pix_we_odd1,
  input  logic [DW-1:0] pix_din_even1,
  input  logic [DW-1:0] pix_din_odd1,
  input  logic [DW-1:0] pix_left1,
  input  logic [DW-1:0] pix_right1,
  output logic [DW-1:0] pix_dout_even1,
  output logic [DW-1:0] pix_dout_odd1,
  input  logic          pix_even_odd,
  input  logic          pix_fwd_inv,
  input  logic          pix_p
);

  // Two guard bits keep (left + right + 2) exact before the arithmetic shift.
  function automatic logic [DW-1:0] lift(
    input logic [DW-1:0] din,
    input logic [DW-1:0] left,
    input logic [DW-1:0] right,
    input logic          upd,
    input logic          fwd
  );
    logic signed [DW+1:0] s;
    logic signed [DW+1:0] d;
    s = $signed({{2{left[DW-1]}}, left}) + $signed({{2{right[DW-1]}}, right});
    if (upd) begin
      d = (s + $signed({{DW{1'b0}}, 2'b10})) >>> 2'd2;
    end else begin
      d = s >>> 2'd1;
    end
    case ({upd, fwd})
      2'b00:   lift = din + d[DW-1:0];
      2'b01:   lift = din - d[DW-1:0];
      2'b10:   lift = din - d[DW-1:0];
      2'b11:   lift = din + d[DW-1:0];
      default: lift = din;
    endcase
  endfunction

  logic [DW-1:0] wv_even0_s;
  logic [DW-1:0] wv_odd0_s;
  logic [DW-1:0] wv_even1_s;
  logic [DW-1:0] wv_odd1_s;

  assign wv_even0_s = pix_p ? lift(pix_din_even,  pix_left,  pix_right,  pix_even_odd, pix_fwd_inv) : pix_din_even;
  assign wv_odd0_s  = pix_p ? lift(pix_din_odd,   pix_left,  pix_right,  pix_even_odd, pix_fwd_inv) : pix_din_odd;
  assign wv_even1_s = pix_p ? lift(pix_din_even1, pix_left1, pix_right1, pix_even_odd, pix_fwd_inv) : pix_din_even1;
  assign wv_odd1_s  = pix_p ? lift(pix_din_odd1,  pix_left1, pix_right1, pix_even_odd, pix_fwd_inv) : pix_din_odd1;

  ram_even_bank_ram #(.DW(DW), .AW(AW)) u_even0 (
    .clk(clk), .rst(rst), .addr(pix_addr_even), .we(pix_we_even), .wv(wv_even0_s), .dout(pix_dout_even)
  );
  ram_even_bank_ram #(.DW(DW), .AW(AW)) u_odd0 (
    .clk(clk), .rst(rst), .addr(pix_addr_odd), .we(pix_we_odd), .wv(wv_odd0_s), .dout(pix_dout_odd)
  );
  ram_even_bank_ram #(.DW(DW), .AW(AW)) u_even1 (
    .clk(clk), .rst(rst), .addr(pix_addr_even1), .we(pix_we_even1), .wv(wv_even1_s), .dout(pix_dout_even1)
  );
  ram_even_bank_ram #(.DW(DW), .AW(AW)) u_odd1 (
    .clk(clk), .rst(rst), .addr(pix_addr_odd1), .we(pix_we_odd1), .wv(wv_odd1_s), .dout(pix_dout_odd1)
  );

endmodule

// File: tb/tb_ram_even_bank.sv
// Self-checking bench for ram_even_bank: directed lifting vectors, corner sequences and
// randomized traffic against an integer-arithmetic reference model. RAM index: 0=ch0 even,
// 1=ch0 odd, 2=ch1 even, 3=ch1 odd.

module tb_ram_even_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  addr [4];
  logic        we   [4];
  logic [19:0] din  [4];
  logic [19:0] left [2];
  logic [19:0] right[2];
  logic        eo, fi, p;
  logic [19:0] dout [4];

  int errors = 0;
  int checks = 0;

  logic [19:0] mdl [4][128];
  bit          vld [4][128];

  typedef struct {
    int          ram;
    bit          p;
    bit          eo;
    bit          fi;
    logic [19:0] din;
    logic [19:0] l;
    logic [19:0] r;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  ram_even_bank dut (
    .clk(clk), .rst(rst),
    .pix_addr_even(addr[0]), .pix_addr_odd(addr[1]),
    .pix_we_even(we[0]), .pix_we_odd(we[1]),
    .pix_din_even(din[0]), .pix_din_odd(din[1]),
    .pix_left(left[0]), .pix_right(right[0]),
    .pix_dout_even(dout[0]), .pix_dout_odd(dout[1]),
    .pix_addr_even1(addr[2]), .pix_addr_odd1(addr[3]),
    .pix_we_even1(we[2]), .pix_we_odd1(we[3]),
    .pix_din_even1(din[2]), .pix_din_odd1(din[3]),
    .pix_left1(left[1]), .pix_right1(right[1]),
    .pix_dout_even1(dout[2]), .pix_dout_odd1(dout[3]),
    .pix_even_odd(eo), .pix_fwd_inv(fi), .pix_p(p)
  );

  // Reference lifting step in plain signed integers.
  function automatic logic [19:0] ref_lift(input bit rp, input bit reo, input bit rfi,
                                           input logic [19:0] x, input logic [19:0] l,
                                           input logic [19:0] r);
    int s, d, xi, res;
    if (!rp) return x;
    s  = $signed(l) + $signed(r);
    xi = $signed(x);
    if (reo) d = (s + 2) >>> 2;
    else     d = s >>> 1;
    if (!reo) res = rfi ? xi - d : xi + d;
    else      res = rfi ? xi + d : xi - d;
    return res[19:0];
  endfunction

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", nm, act, exp);
    end
  endtask

  // One clock: predict douts from the model, clock, compare, commit writes.
  task automatic run_cycle();
    logic [19:0] exp [4];
    logic [19:0] wv  [4];
    bit          known [4];
    for (int r = 0; r < 4; r++) begin
      wv[r] = ref_lift(p, eo, fi, din[r], left[r/2], right[r/2]);
      if (rst) begin
        exp[r] = 20'h0;
        known[r] = 1'b1;
      end else begin
`ifdef RD_BYPASS_EN
        known[r] = we[r] || vld[r][addr[r]];
        exp[r]   = we[r] ? wv[r] : mdl[r][addr[r]];
`else
        known[r] = vld[r][addr[r]];
        exp[r]   = mdl[r][addr[r]];
`endif
      end
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) begin
      if (known[r]) chk($sformatf("model_dout%0d", r), dout[r], exp[r]);
      if (!rst && we[r]) begin
        mdl[r][addr[r]] = wv[r];
        vld[r][addr[r]] = 1'b1;
      end
    end
  endtask

  task automatic idle_we();
    for (int r = 0; r < 4; r++) we[r] = 1'b0;
  endtask

  initial begin
    tbl[0] = '{0, 1'b0, 1'b0, 1'b0, 20'h12345, 20'h0,     20'h0,     20'h12345};
    tbl[1] = '{1, 1'b1, 1'b0, 1'b1, 20'd100,   20'd40,    20'd61,    20'd50};
    tbl[2] = '{1, 1'b1, 1'b0, 1'b0, 20'd50,    20'd40,    20'd61,    20'd100};
    tbl[3] = '{2, 1'b1, 1'b1, 1'b1, 20'd10,    20'd5,     20'd6,     20'd13};
    tbl[4] = '{2, 1'b1, 1'b1, 1'b0, 20'd13,    20'd5,     20'd6,     20'd10};
    tbl[5] = '{1, 1'b1, 1'b0, 1'b1, 20'h0,     20'hFFFFD, 20'h0,     20'h00002};
    tbl[6] = '{0, 1'b1, 1'b1, 1'b1, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'hBFFFF};
    tbl[7] = '{3, 1'b1, 1'b0, 1'b0, 20'h0,     20'hFFFFD, 20'h0,     20'hFFFFE};
    tbl[8] = '{3, 1'b1, 1'b1, 1'b0, 20'h0,     20'hFFFFF, 20'hFFFFE, 20'h00001};

    for (int r = 0; r < 4; r++)
      for (int a = 0; a < 128; a++) vld[r][a] = 1'b0;

    rst = 1'b1; p = 1'b0; eo = 1'b0; fi = 1'b0;
    for (int r = 0; r < 4; r++) begin addr[r] = 7'd0; we[r] = 1'b0; din[r] = 20'h0; end
    for (int c = 0; c < 2; c++) begin left[c] = 20'h0; right[c] = 20'h0; end
    run_cycle();
    run_cycle();
    for (int r = 0; r < 4; r++) chk($sformatf("reset_dout%0d", r), dout[r], 20'h0);

    // Fill every location with raw data so later reads are defined.
    rst = 1'b0;
    for (int a = 0; a < 128; a++) begin
      for (int r = 0; r < 4; r++) begin
        we[r] = 1'b1; addr[r] = 7'(a); din[r] = 20'($urandom);
      end
      run_cycle();
    end
    idle_we();

    // Directed lifting vectors: write, then read back one cycle later.
    for (int i = 0; i < 9; i++) begin
      idle_we();
      for (int r = 0; r < 4; r++) addr[r] = 7'(r + 1);
      p = tbl[i].p; eo = tbl[i].eo; fi = tbl[i].fi;
      for (int c = 0; c < 2; c++) begin left[c] = tbl[i].l; right[c] = tbl[i].r; end
      we[tbl[i].ram] = 1'b1;
      addr[tbl[i].ram] = 7'(100 + i);
      din[tbl[i].ram] = tbl[i].din;
      run_cycle();
      idle_we();
      run_cycle();
      chk($sformatf("vec%0d", i), dout[tbl[i].ram], tbl[i].exp);
    end

    // All four RAMs written in the same cycle, then read back together.
    p = 1'b0;
    for (int r = 0; r < 4; r++) begin
      we[r] = 1'b1; addr[r] = 7'(10 * (r + 1)); din[r] = 20'hA0000 + 20'(r * 4369);
    end
    run_cycle();
    idle_we();
    run_cycle();
    for (int r = 0; r < 4; r++)
      chk($sformatf("concurrent%0d", r), dout[r], 20'hA0000 + 20'(r * 4369));

    // Same-address read during write.
    for (int r = 0; r < 4; r++) begin we[r] = 1'b1; addr[r] = 7'd50; din[r] = 20'h11110 + 20'(r); end
    run_cycle();
    for (int r = 0; r < 4; r++) din[r] = 20'h22220 + 20'(r);
    run_cycle();
    for (int r = 0; r < 4; r++) begin
`ifdef RD_BYPASS_EN
      chk($sformatf("rw_same%0d", r), dout[r], 20'h22220 + 20'(r));
`else
      chk($sformatf("rw_same%0d", r), dout[r], 20'h11110 + 20'(r));
`endif
    end
    idle_we();
    run_cycle();
    for (int r = 0; r < 4; r++) chk($sformatf("rw_after%0d", r), dout[r], 20'h22220 + 20'(r));

    // Reset while writing: write is dropped, earlier contents survive.
    for (int r = 0; r < 4; r++) begin we[r] = 1'b1; addr[r] = 7'd60; din[r] = 20'h0C0C0 + 20'(r); end
    run_cycle();
    rst = 1'b1;
    for (int r = 0; r < 4; r++) din[r] = 20'h0D0D0 + 20'(r);
    run_cycle();
    for (int r = 0; r < 4; r++) chk($sformatf("rst_mid_dout%0d", r), dout[r], 20'h0);
    rst = 1'b0;
    idle_we();
    run_cycle();
    for (int r = 0; r < 4; r++) chk($sformatf("rst_keep%0d", r), dout[r], 20'h0C0C0 + 20'(r));

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 31) == 0);
      p  = 1'($urandom_range(0, 1));
      eo = 1'($urandom_range(0, 1));
      fi = 1'($urandom_range(0, 1));
      for (int r = 0; r < 4; r++) begin
        we[r] = 1'($urandom_range(0, 1));
        addr[r] = 7'($urandom_range(0, 127));
        din[r] = 20'($urandom);
      end
      for (int c = 0; c < 2; c++) begin left[c] = 20'($urandom); right[c] = 20'($urandom); end
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
